rv32_data_arbiter: RTL and testbench
====================================

# rv32_data_arbiter

Two-master arbiter for the rv32 data bus. It shares the single downstream data path (main memory plus NUM_MMIO MMIO slaves) between the core data port (master 0) and a debug/DMA port (master 1). Only one transaction is outstanding at a time. The block picks the responding slave, returns read data and a one-cycle response to the granted master, and optionally aborts hung transactions with a watchdog.

## Interface
- NUM_MMIO, default rv32_types::NUM_MMIO, number of MMIO slaves (≥1)
- TIMEOUT_CYCLES, default 256, BUSY cycles before abort (≥2, timeout build only)
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- m_req_valid  in  [2]  request per master; held until accepted
- m_req_ready  out  [2]  accept pulse, one-hot
- m_req_addr / m_req_wdata  in  [2][32]  address / write data per master
- m_req_we  in  [2]  1 = write
- m_req_be  in  [2][4]  byte enables
- m_rsp_valid  out  [2]  one-cycle response pulse, one-hot
- m_rsp_rdata  out  32  shared read data, valid with m_rsp_valid
- m_rsp_err  out  1  response is a timeout abort
- bus_req_valid  out  1  downstream request
- bus_req_addr / bus_req_wdata  out  32  latched address / data
- bus_req_we  out  1; bus_req_be  out  4
- bus_master_id  out  1  granted master
- mem_done  in  1; mem_rdata  in  32  main memory done / data
- mmio_done  in  [NUM_MMIO]; mmio_rdata  in  [NUM_MMIO][32]

## Operation
- FSM states: IDLE, BUSY, RESP. Reset puts it in IDLE. Every output is 0 in reset. last_grant resets to 1, so master 0 wins the first tie.
- IDLE
  - No request: stay.
  - One master requesting: grant it.
  - Both requesting: grant !last_grant (round-robin).
  - On grant: m_req_ready[g]=1 (combinational), latch addr/wdata/we/be/g, update last_grant, go to BUSY.
- BUSY
  - bus_req_valid=1 with latched fields, held stable.
  - On the first cycle mem_done or any mmio_done is high: register the slave select and go to RESP.
  - Select priority: memory, then the highest MMIO index.
- RESP
  - m_rsp_valid[g]=1. m_rsp_rdata is driven combinationally from the registered selected slave (its data is valid the cycle after done).
  - m_rsp_err=0. Next state is IDLE.
- Writes get a response pulse exactly like reads; rdata is don't-care.
- Done inputs in IDLE or RESP are ignored.
- No new grant is made in BUSY or RESP, even if a master is requesting.
- Reset asserted mid-transaction: next cycle is IDLE, the transaction is dropped, no response is issued.

## Timing
- Accept at cycle T (IDLE). bus_req_valid is high from T+1.
- Done at cycle D ≥ T+1 → m_rsp_valid at D+1 → earliest next accept at D+2.
- Minimum round trip is 2 cycles from accept to response; back-to-back throughput is one transaction per 3 cycles.
- bus_req_valid deasserts in the RESP cycle.
- m_req_ready and m_rsp_valid are never high for both masters in the same cycle.

## Configuration
- RV32_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) clears on entering BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with no done, go to RESP with m_rsp_err=1 and m_rsp_rdata=0.
  - A done arriving on the expiry cycle wins: normal response, err=0.
  - A late done arriving afterwards in IDLE is ignored.
- RV32_ARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, m_rsp_err is tied to 0, and TIMEOUT_CYCLES is unused.

## Structure
- rv32_types gains the arb_state_t enum (IDLE/BUSY/RESP) and the constant ARB_NUM_MASTERS=2.
- One sub-module, rv32_bus_resp_mux:
  - Combinational priority encoder from mem_done/mmio_done to a slave index.
  - Data mux from the registered index to the read word.
  - Reusable by rv32_top.

## Test plan
- Single read: master 0 reads 0x100; mem_done at T+3 with mem_rdata=0xCAFEF00D the next cycle → m_rsp_valid[0] at T+4 with rdata 0xCAFEF00D and err 0.
- Contention: both masters request continuously for 4 transactions → grants alternate 0,1,0,1; bus_master_id matches; each response goes to the granted master only.
- Simultaneous done: mem_done, mmio_done[0] and mmio_done[1] all high with distinct data → memory data returned. Repeat with only the mmio_done bits → mmio_rdata[NUM_MMIO-1] returned.
- Timeout (macro on, TIMEOUT_CYCLES=4): no done → m_rsp_err=1 and rdata 0 on the 5th cycle after accept. Done exactly at expiry → err=0.
- Reset mid-BUSY: assert reset for 1 cycle → all outputs 0 next cycle and no m_rsp_valid. The next request is granted to master 0 even if master 1 also requests.
- Write with spurious done: a mmio_done pulse in IDLE is ignored. A master 1 write to 0x2000 with be=0x3 drives the latched fields until done, then a response pulse with err 0.

Source files
------------

// File: rtl/rv32_types.sv
// Shared rv32 bus types: MMIO count, arbiter state encoding and request payload.
// Imported by the data arbiter and the response mux.
package rv32_types;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned NUM_MMIO        = 2;
  localparam int unsigned ARB_NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [3:0]      be;
  } bus_req_t;

endpackage

// File: rtl/rv32_bus_resp_mux.sv
// Responding-slave selection for the rv32 data bus: priority encoder over the done
// lines (memory first, then highest MMIO) and read-data mux from a registered index.
module rv32_bus_resp_mux
  import rv32_types::*;
#(
  parameter int unsigned NUM_MMIO = rv32_types::NUM_MMIO,
  parameter int unsigned SEL_W    = $clog2(NUM_MMIO + 1)
) (
  input  logic                           mem_done_i,
  input  logic [XLEN-1:0]                mem_rdata_i,
  input  logic [NUM_MMIO-1:0]            mmio_done_i,
  input  logic [NUM_MMIO-1:0][XLEN-1:0]  mmio_rdata_i,
  input  logic [SEL_W-1:0]               sel_q_i,
  output logic                           any_done_c_o,
  output logic [SEL_W-1:0]               sel_c_o,
  output logic [XLEN-1:0]                rdata_c_o
);

  assign any_done_c_o = mem_done_i | (|mmio_done_i);

  // Index 0 is memory, index i+1 is MMIO slave i; later loop hits win.
  always_comb begin
    sel_c_o = '0;
    for (int i = 0; i < NUM_MMIO; i++) begin
      if (mmio_done_i[i]) sel_c_o = SEL_W'(i + 1);
    end
    if (mem_done_i) sel_c_o = '0;
  end

  always_comb begin
    rdata_c_o = mem_rdata_i;
    for (int i = 0; i < NUM_MMIO; i++) begin
      if (sel_q_i == SEL_W'(i + 1)) rdata_c_o = mmio_rdata_i[i];
    end
  end

endmodule

// File: rtl/rv32_data_arbiter.sv
// Two-master round-robin arbiter for the shared rv32 data bus, one transaction in flight.
// Optional hung-transaction watchdog enabled by defining RV32_ARB_TIMEOUT_EN.
module rv32_data_arbiter #(
  parameter int unsigned NUM_MMIO       = rv32_types::NUM_MMIO,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [rv32_types::ARB_NUM_MASTERS-1:0]            m_req_valid,
  output logic [rv32_types::ARB_NUM_MASTERS-1:0]            m_req_ready,
  input  logic [rv32_types::ARB_NUM_MASTERS-1:0][31:0]      m_req_addr,
  input  logic [rv32_types::ARB_NUM_MASTERS-1:0][31:0]      m_req_wdata,
  input  logic [rv32_types::ARB_NUM_MASTERS-1:0]            m_req_we,
  input  logic [rv32_types::ARB_NUM_MASTERS-1:0][3:0]       m_req_be,
  output logic [rv32_types::ARB_NUM_MASTERS-1:0]            m_rsp_valid,
  output logic [31:0]                                       m_rsp_rdata,
  output logic                                              m_rsp_err,
  output logic                                              bus_req_valid,
  output logic [31:0]                                       bus_req_addr,
  output logic [31:0]                                       bus_req_wdata,
  output logic                                              bus_req_we,
  output logic [3:0]                                        bus_req_be,
  output logic                                              bus_master_id,
  input  logic                                              mem_done,
  input  logic [31:0]                                       mem_rdata,
  input  logic [NUM_MMIO-1:0]                               mmio_done,
  input  logic [NUM_MMIO-1:0][31:0]                         mmio_rdata
);
  import rv32_types::*;

  localparam int unsigned SEL_W = $clog2(NUM_MMIO + 1);

  arb_state_t              state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  bus_req_t                req_q, req_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ARB_NUM_MASTERS-1:0] ready_c;
  logic                    gnt_c;
  logic                    any_done_c;
  logic [SEL_W-1:0]        sel_c;
  logic [XLEN-1:0]         mux_rdata_c;
  logic                    rsp_c;

`ifdef RV32_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

  rv32_bus_resp_mux #(
    .NUM_MMIO (NUM_MMIO),
    .SEL_W    (SEL_W)
  ) u_resp_mux (
    .mem_done_i   (mem_done),
    .mem_rdata_i  (mem_rdata),
    .mmio_done_i  (mmio_done),
    .mmio_rdata_i (mmio_rdata),
    .sel_q_i      (sel_q),
    .any_done_c_o (any_done_c),
    .sel_c_o      (sel_c),
    .rdata_c_o    (mux_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      req_q        <= '0;
      sel_q        <= '0;
`ifdef RV32_ARB_TIMEOUT_EN
      err_q        <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      req_q        <= req_d;
      sel_q        <= sel_d;
`ifdef RV32_ARB_TIMEOUT_EN
      err_q        <= err_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    req_d        = req_q;
    sel_d        = sel_q;
    ready_c      = '0;
    gnt_c        = 1'b0;
`ifdef RV32_ARB_TIMEOUT_EN
    err_d        = err_q;
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|m_req_valid) begin
          // Contention goes to the master that did not win last time.
          gnt_c          = (&m_req_valid) ? ~last_grant_q : m_req_valid[1];
          ready_c[gnt_c] = 1'b1;
          req_d.addr     = m_req_addr[gnt_c];
          req_d.wdata    = m_req_wdata[gnt_c];
          req_d.we       = m_req_we[gnt_c];
          req_d.be       = m_req_be[gnt_c];
          grant_d        = gnt_c;
          last_grant_d   = gnt_c;
          state_d        = BUSY;
`ifdef RV32_ARB_TIMEOUT_EN
          err_d          = 1'b0;
          cnt_d          = '0;
`endif
        end
      end
      BUSY: begin
        if (any_done_c) begin
          sel_d   = sel_c;
          state_d = RESP;
        end
`ifdef RV32_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_c = !reset && (state_q == RESP);

  always_comb begin
    m_rsp_valid = '0;
    if (rsp_c) m_rsp_valid[grant_q] = 1'b1;
  end

  assign m_req_ready   = reset ? '0 : ready_c;
  assign bus_req_valid = !reset && (state_q == BUSY);
  assign bus_req_addr  = reset ? '0 : req_q.addr;
  assign bus_req_wdata = reset ? '0 : req_q.wdata;
  assign bus_req_we    = !reset && req_q.we;
  assign bus_req_be    = reset ? '0 : req_q.be;
  assign bus_master_id = !reset && grant_q;

`ifdef RV32_ARB_TIMEOUT_EN
  assign m_rsp_err   = rsp_c && err_q;
  assign m_rsp_rdata = (rsp_c && !err_q) ? mux_rdata_c : '0;
`else
  assign m_rsp_err   = 1'b0;
  assign m_rsp_rdata = rsp_c ? mux_rdata_c : '0;
`endif

endmodule

// File: tb/tb_rv32_data_arbiter.sv
// Directed scoreboard bench for rv32_data_arbiter; timeout cases compiled in when
// RV32_ARB_TIMEOUT_EN is defined (watchdog length 4).
module tb_rv32_data_arbiter;

  localparam int unsigned NM = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        m_req_valid;
  logic [1:0]        m_req_ready;
  logic [1:0][31:0]  m_req_addr;
  logic [1:0][31:0]  m_req_wdata;
  logic [1:0]        m_req_we;
  logic [1:0][3:0]   m_req_be;
  logic [1:0]        m_rsp_valid;
  logic [31:0]       m_rsp_rdata;
  logic              m_rsp_err;
  logic              bus_req_valid;
  logic [31:0]       bus_req_addr;
  logic [31:0]       bus_req_wdata;
  logic              bus_req_we;
  logic [3:0]        bus_req_be;
  logic              bus_master_id;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [NM-1:0]     mmio_done;
  logic [NM-1:0][31:0] mmio_rdata;

  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
    logic        cmp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  rv32_data_arbiter #(.NUM_MMIO(NM), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_req_addr    (m_req_addr),
    .m_req_wdata   (m_req_wdata),
    .m_req_we      (m_req_we),
    .m_req_be      (m_req_be),
    .m_rsp_valid   (m_rsp_valid),
    .m_rsp_rdata   (m_rsp_rdata),
    .m_rsp_err     (m_rsp_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_we    (bus_req_we),
    .bus_req_be    (bus_req_be),
    .bus_master_id (bus_master_id),
    .mem_done      (mem_done),
    .mem_rdata     (mem_rdata),
    .mmio_done     (mmio_done),
    .mmio_rdata    (mmio_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [31:0] rdata, input logic err, input logic cmp);
    exp_t e;
    e.m = m; e.rdata = rdata; e.err = err; e.cmp = cmp;
    exp_q.push_back(e);
  endtask

  // Inputs change right after the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic mon();
    exp_t e;
    logic [1:0] oh;
    #1;
    if (m_rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(m_rsp_valid), 32'h0);
      end else begin
        e  = exp_q.pop_front();
        oh = 2'b01 << e.m;
        chk("rsp_master", 32'(m_rsp_valid), 32'(oh));
        if (e.cmp) chk("rsp_rdata", m_rsp_rdata, e.rdata);
        chk("rsp_err", 32'(m_rsp_err), 32'(e.err));
      end
    end
  endtask

  task automatic do_reset(input int n);
    cyc();
    reset = 1'b1; m_req_valid = '0; mem_done = 1'b0; mmio_done = '0;
    repeat (n) cyc();
    reset = 1'b0;
  endtask

  task automatic xact(input string tag, input logic m, input logic [31:0] addr,
                      input logic we, input logic [3:0] be, input logic [31:0] wdata,
                      input int hold, input logic md, input logic [1:0] mmd,
                      input logic [31:0] exp_rdata, input logic cmp);
    logic [1:0] oh;
    oh = 2'b01 << m;
    cyc();
    m_req_valid[m] = 1'b1; m_req_addr[m] = addr; m_req_we[m] = we;
    m_req_be[m] = be; m_req_wdata[m] = wdata;
    mon();
    chk({tag, "_ready"}, 32'(m_req_ready), 32'(oh));
    cyc();
    m_req_valid[m] = 1'b0;
    mon();
    chk({tag, "_bus_valid"}, 32'(bus_req_valid), 32'h1);
    chk({tag, "_bus_addr"},  bus_req_addr, addr);
    chk({tag, "_bus_we"},    32'(bus_req_we), 32'(we));
    chk({tag, "_bus_be"},    32'(bus_req_be), 32'(be));
    chk({tag, "_bus_wdata"}, bus_req_wdata, wdata);
    chk({tag, "_bus_id"},    32'(bus_master_id), 32'(m));
    repeat (hold) begin
      cyc(); mon();
      chk({tag, "_hold_valid"}, 32'(bus_req_valid), 32'h1);
      chk({tag, "_hold_addr"},  bus_req_addr, addr);
    end
    cyc();
    mem_done = md; mmio_done = mmd;
    push(m, exp_rdata, 1'b0, cmp);
    mon();
    cyc();
    mem_done = 1'b0; mmio_done = '0;
    mon();
    chk({tag, "_latency"}, 32'(exp_q.size()), 32'h0);
    chk({tag, "_bus_drop"}, 32'(bus_req_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    logic g;
    logic cur;
    reset = 1'b1;
    m_req_valid = '0; m_req_addr = '0; m_req_wdata = '0; m_req_we = '0; m_req_be = '0;
    mem_done = 1'b0; mem_rdata = '0; mmio_done = '0; mmio_rdata = '0;

    // Reset state
    do_reset(2);
    cyc(); mon();
    chk("rst_ready",     32'(m_req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'h0);
    chk("rst_rsp_err",   32'(m_rsp_err), 32'h0);
    chk("rst_bus_valid", 32'(bus_req_valid), 32'h0);
    chk("rst_bus_addr",  bus_req_addr, 32'h0);
    chk("rst_bus_id",    32'(bus_master_id), 32'h0);

    // Single read: done at T+3, response at T+4
    mem_rdata = 32'hCAFEF00D;
    xact("rd0", 1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 1, 1'b1, 2'b00, 32'hCAFEF00D, 1'b1);

    // Simultaneous done priority
    mem_rdata = 32'hA1A1A1A1;
    mmio_rdata[0] = 32'hB0B0B0B0;
    mmio_rdata[1] = 32'hC1C1C1C1;
    xact("pri_mem",  1'b0, 32'h200, 1'b0, 4'hF, 32'h0, 0, 1'b1, 2'b11, 32'hA1A1A1A1, 1'b1);
    xact("pri_mmio", 1'b0, 32'h204, 1'b0, 4'hF, 32'h0, 0, 1'b0, 2'b11, 32'hC1C1C1C1, 1'b1);
    xact("mmio0",    1'b1, 32'h208, 1'b0, 4'hF, 32'h0, 0, 1'b0, 2'b01, 32'hB0B0B0B0, 1'b1);

    // Spurious done in IDLE, then a master 1 write
    cyc(); mmio_done = 2'b01; mem_done = 1'b1; mon();
    chk("spur_bus_valid", 32'(bus_req_valid), 32'h0);
    cyc(); mmio_done = '0; mem_done = 1'b0; mon();
    chk("spur_bus_valid2", 32'(bus_req_valid), 32'h0);
    xact("wr1", 1'b1, 32'h2000, 1'b1, 4'h3, 32'h12345678, 2, 1'b0, 2'b01, 32'h0, 1'b0);

    // Contention from a fresh reset: grants alternate 0,1,0,1
    do_reset(1);
    n = 0; g = 1'b0; cur = 1'b0;
    for (int k = 0; k < 40 && !(n == 4 && exp_q.size() == 0); k++) begin
      cyc();
      if (k == 0) begin
        m_req_valid = 2'b11; mem_done = 1'b1;
        m_req_addr[0] = 32'h400; m_req_addr[1] = 32'h800; m_req_we = '0;
      end
      if (n == 4) m_req_valid = '0;
      mon();
      if (m_req_ready != 2'b00) begin
        chk("cont_grant", 32'(m_req_ready), 32'(2'b01 << g));
        mem_rdata = 32'hD0000000 | 32'(n);
        push(g, mem_rdata, 1'b0, 1'b1);
        cur = g; g = ~g; n++;
      end else if (bus_req_valid) begin
        chk("cont_bus_id", 32'(bus_master_id), 32'(cur));
      end
    end
    chk("cont_count", 32'(n), 32'd4);
    chk("cont_drain", 32'(exp_q.size()), 32'h0);
    cyc(); m_req_valid = '0; mem_done = 1'b0; mon();

    // Reset in BUSY drops the transaction and restores master-0 priority
    cyc(); m_req_valid[0] = 1'b1; m_req_addr[0] = 32'h300; mon();
    chk("rb_ready", 32'(m_req_ready), 32'h1);
    cyc(); m_req_valid = '0; mon();
    chk("rb_busy", 32'(bus_req_valid), 32'h1);
    cyc(); reset = 1'b1; mon();
    chk("rb_in_rst_valid", 32'(bus_req_valid), 32'h0);
    cyc(); reset = 1'b0; mon();
    chk("rb_after_valid", 32'(bus_req_valid), 32'h0);
    chk("rb_after_rsp",   32'(m_rsp_valid), 32'h0);
    chk("rb_after_addr",  bus_req_addr, 32'h0);
    chk("rb_after_id",    32'(bus_master_id), 32'h0);
    cyc(); m_req_valid = 2'b11; m_req_addr[0] = 32'h500; m_req_addr[1] = 32'h600; mon();
    chk("rb_regrant", 32'(m_req_ready), 32'h1);
    cyc(); m_req_valid = '0; mon();
    chk("rb_regrant_id", 32'(bus_master_id), 32'h0);
    mem_rdata = 32'h5A5A0001;
    cyc(); mem_done = 1'b1; push(1'b0, 32'h5A5A0001, 1'b0, 1'b1); mon();
    cyc(); mem_done = 1'b0; mon();
    chk("rb_latency", 32'(exp_q.size()), 32'h0);

`ifdef RV32_ARB_TIMEOUT_EN
    // Watchdog expiry: error response on the 5th cycle after accept
    mem_rdata = 32'hDEADBEEF;
    cyc(); m_req_valid[0] = 1'b1; m_req_addr[0] = 32'h700; mon();
    chk("to_ready", 32'(m_req_ready), 32'h1);
    cyc(); m_req_valid = '0; mon();
    repeat (3) begin cyc(); mon(); end
    cyc(); push(1'b0, 32'h0, 1'b1, 1'b1); mon();
    chk("to_latency", 32'(exp_q.size()), 32'h0);
    cyc(); mem_done = 1'b1; mon();
    cyc(); mem_done = 1'b0; mon();
    chk("to_late_done", 32'(m_rsp_valid), 32'h0);

    // Done on the expiry cycle wins
    cyc(); m_req_valid[0] = 1'b1; m_req_addr[0] = 32'h704; mon();
    cyc(); m_req_valid = '0; mon();
    repeat (2) begin cyc(); mon(); end
    cyc(); mem_done = 1'b1; push(1'b0, 32'hDEADBEEF, 1'b0, 1'b1); mon();
    cyc(); mem_done = 1'b0; mon();
    chk("to_edge_latency", 32'(exp_q.size()), 32'h0);
`endif

    repeat (3) begin cyc(); mon(); end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
